operand_broadcaster: RTL

Transmit side of the stripe operand bus. Accepts a job descriptor, broadcasts one configuration beat (instruction, base tags, strides, iteration limit) with `en_tag_write`, then fetches and drives tagged operand blocks. Each beat carries A and B data plus their tags, which the stripes match against their own tag sequences. Sits between the operand SRAM and the `Stripe` array; all stripes share its output bus.

---
 rtl/bcast_pkg.sv | 17 +
 rtl/tag_seq.sv | 32 +++
 rtl/operand_broadcaster.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/bcast_pkg.sv
// rtl/bcast_pkg.sv - shared state encoding and default widths for the operand broadcaster
package bcast_pkg;

    localparam int DEF_BLOCK_WIDTH = 128;
    localparam int DEF_TAG_WIDTH   = 12;
    localparam int DEF_INSTR_WIDTH = 7;
    localparam int LANE_WIDTH      = 16;

    typedef enum logic [2:0] {
        IDLE,
        CONFIG,
        FETCH,
        WAIT,
        SEND
    } state_t;

endpackage

// File: rtl/tag_seq.sv
// rtl/tag_seq.sv - load/step tag counter with modulo-2^W stride add
module tag_seq #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         step,
    input  logic [W-1:0] base,
    input  logic [W-1:0] stride,
    output logic [W-1:0] tag,
    output logic [W-1:0] tag_next
);

    logic [W-1:0] stride_q;

    // Truncation to W bits gives the silent wrap-around the stripes expect.
    assign tag_next = tag + stride_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stride_q <= '0;
            tag      <= '0;
        end else if (load) begin
            stride_q <= stride;
            tag      <= base;
        end else if (step) begin
            tag <= tag_next;
        end
    end

endmodule

// File: rtl/operand_broadcaster.sv
// rtl/operand_broadcaster.sv - stripe operand bus transmitter (BCAST_STATS_EN adds beat/stall counters)
module operand_broadcaster
    import bcast_pkg::*;
#(
    parameter int BLOCK_WIDTH = bcast_pkg::DEF_BLOCK_WIDTH,
    parameter int TAG_WIDTH   = bcast_pkg::DEF_TAG_WIDTH,
    parameter int INSTR_WIDTH = bcast_pkg::DEF_INSTR_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   job_valid,
    output logic                   job_ready,
    input  logic [INSTR_WIDTH-1:0] job_instr,
    input  logic [TAG_WIDTH-1:0]   job_base_a,
    input  logic [TAG_WIDTH-1:0]   job_base_b,
    input  logic [TAG_WIDTH-1:0]   job_stride_a,
    input  logic [TAG_WIDTH-1:0]   job_stride_b,
    input  logic [TAG_WIDTH-1:0]   job_count,
    output logic                   mem_rd,
    output logic [TAG_WIDTH-1:0]   mem_addr_a,
    output logic [TAG_WIDTH-1:0]   mem_addr_b,
    input  logic [BLOCK_WIDTH-1:0] mem_rdata_a,
    input  logic [BLOCK_WIDTH-1:0] mem_rdata_b,
    output logic                   en_tag_write,
    output logic [INSTR_WIDTH-1:0] instr_OUT,
    output logic [TAG_WIDTH-1:0]   strideA_OUT,
    output logic [TAG_WIDTH-1:0]   strideB_OUT,
    output logic [TAG_WIDTH-1:0]   iter_count_OUT,
    output logic [TAG_WIDTH-1:0]   iter_lim_OUT,
    output logic [TAG_WIDTH-1:0]   tagA_OUT,
    output logic [TAG_WIDTH-1:0]   tagB_OUT,
    output logic                   bus_valid,
    input  logic                   bus_ready,
    output logic [BLOCK_WIDTH-1:0] d0_OUT,
    output logic [BLOCK_WIDTH-1:0] d1_OUT,
    output logic                   job_done
`ifdef BCAST_STATS_EN
    ,
    output logic [31:0]            stat_beats,
    output logic [31:0]            stat_stalls
`endif
);

    state_t               state;
    logic [TAG_WIDTH-1:0] remaining;
    logic [TAG_WIDTH-1:0] tag_a, tag_a_next, tag_b, tag_b_next;
    logic                 seq_load, seq_step;

    assign seq_load = (state == IDLE) && job_valid;
    assign seq_step = (state == SEND) && bus_ready;

    tag_seq #(.W(TAG_WIDTH)) u_seq_a (
        .clk(clk), .rst(rst), .load(seq_load), .step(seq_step),
        .base(job_base_a), .stride(job_stride_a), .tag(tag_a), .tag_next(tag_a_next)
    );

    tag_seq #(.W(TAG_WIDTH)) u_seq_b (
        .clk(clk), .rst(rst), .load(seq_load), .step(seq_step),
        .base(job_base_b), .stride(job_stride_b), .tag(tag_b), .tag_next(tag_b_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            remaining      <= '0;
            job_ready      <= 1'b1;
            mem_rd         <= 1'b0;
            mem_addr_a     <= '0;
            mem_addr_b     <= '0;
            en_tag_write   <= 1'b0;
            instr_OUT      <= '0;
            strideA_OUT    <= '0;
            strideB_OUT    <= '0;
            iter_count_OUT <= '0;
            iter_lim_OUT   <= '0;
            tagA_OUT       <= '0;
            tagB_OUT       <= '0;
            bus_valid      <= 1'b0;
            d0_OUT         <= '0;
            d1_OUT         <= '0;
            job_done       <= 1'b0;
        end else begin
            en_tag_write <= 1'b0;
            job_done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (job_valid) begin
                        job_ready      <= 1'b0;
                        en_tag_write   <= 1'b1;
                        instr_OUT      <= job_instr;
                        strideA_OUT    <= job_stride_a;
                        strideB_OUT    <= job_stride_b;
                        iter_count_OUT <= '0;
                        iter_lim_OUT   <= job_count;
                        tagA_OUT       <= job_base_a;
                        tagB_OUT       <= job_base_b;
                        remaining      <= job_count;
                        state          <= CONFIG;
                    end
                end
                CONFIG: begin
                    instr_OUT    <= '0;
                    strideA_OUT  <= '0;
                    strideB_OUT  <= '0;
                    iter_lim_OUT <= '0;
                    tagA_OUT     <= '0;
                    tagB_OUT     <= '0;
                    if (remaining == '0) begin
                        job_done  <= 1'b1;
                        job_ready <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        mem_rd     <= 1'b1;
                        mem_addr_a <= tag_a;
                        mem_addr_b <= tag_b;
                        state      <= FETCH;
                    end
                end
                FETCH: begin
                    mem_rd     <= 1'b0;
                    mem_addr_a <= '0;
                    mem_addr_b <= '0;
                    state      <= WAIT;
                end
                WAIT: begin
                    d0_OUT    <= mem_rdata_a;
                    d1_OUT    <= mem_rdata_b;
                    tagA_OUT  <= tag_a;
                    tagB_OUT  <= tag_b;
                    bus_valid <= 1'b1;
                    state     <= SEND;
                end
                SEND: begin
                    if (bus_ready) begin
                        bus_valid <= 1'b0;
                        d0_OUT    <= '0;
                        d1_OUT    <= '0;
                        tagA_OUT  <= '0;
                        tagB_OUT  <= '0;
                        remaining <= remaining - 1'b1;
                        if (remaining == TAG_WIDTH'(1)) begin
                            job_done  <= 1'b1;
                            job_ready <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            // Tag counters step on this same edge, so fetch from the stepped values.
                            mem_rd     <= 1'b1;
                            mem_addr_a <= tag_a_next;
                            mem_addr_b <= tag_b_next;
                            state      <= FETCH;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BCAST_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_beats  <= '0;
            stat_stalls <= '0;
        end else if (state == SEND) begin
            if (bus_ready) stat_beats <= stat_beats + 32'd1;
            else           stat_stalls <= stat_stalls + 32'd1;
        end
    end
`endif

endmodule
